alu_sequencer: RTL and testbench

- Front-end controller for the shared TotalALU.
- Accepts one operation at a time over a valid/ready request port and drives the ALU's Signal, dataA, dataB and reset.
- Sequences the multicycle DIVU: clears the divider, waits out the iterations, then reads HI and LO back through MFHI/MFLO.
- Returns results over a valid/ready response port. Sits between the pipeline EX stage (or a test master) and TotalALU.

---
 rtl/alu_pkg.sv | 43 ++++
 rtl/alu_div_timer.sv | 50 +++++
 rtl/alu_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_alu_sequencer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the TotalALU front end: funct codes, sequencer state encoding
// and op classification.
package alu_pkg;

    localparam int unsigned OP_W   = 6;
    localparam int unsigned DATA_W = 32;

    localparam logic [OP_W-1:0] FN_NOP  = 6'd0;
    localparam logic [OP_W-1:0] FN_SRL  = 6'd2;
    localparam logic [OP_W-1:0] FN_MFHI = 6'd16;
    localparam logic [OP_W-1:0] FN_MFLO = 6'd18;
    localparam logic [OP_W-1:0] FN_DIVU = 6'd27;
    localparam logic [OP_W-1:0] FN_ADD  = 6'd32;
    localparam logic [OP_W-1:0] FN_SUB  = 6'd34;
    localparam logic [OP_W-1:0] FN_AND  = 6'd36;
    localparam logic [OP_W-1:0] FN_OR   = 6'd37;
    localparam logic [OP_W-1:0] FN_SLT  = 6'd42;

    typedef enum logic [2:0] {
        StIdle,
        StExec,
        StDivClr,
        StDivRun,
        StRdHi,
        StRdLo,
        StResp
    } state_e;

    // Ops whose result is on alu_out in the cycle after they are driven.
    function automatic logic is_single_cycle(input logic [OP_W-1:0] op);
        logic single;
        case (op)
            FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT, FN_SRL, FN_MFHI, FN_MFLO: single = 1'b1;
            default:                                                          single = 1'b0;
        endcase
        return single;
    endfunction

    function automatic logic is_div(input logic [OP_W-1:0] op);
        return op == FN_DIVU;
    endfunction

endpackage

// File: rtl/alu_div_timer.sv
// Wait counter for the multicycle divide: counts DivCycles cycles after start_i and
// flags the last one on done_o.
module alu_div_timer #(
    parameter int unsigned DivCycles = 34,
    parameter int unsigned CntW      = 6
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [CntW-1:0] count_o
);

    localparam logic [CntW-1:0] LastCnt = CntW'(DivCycles - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            run_q, run_d;

    assign done_o  = run_q && (cnt_q == LastCnt);
    assign busy_o  = run_q;
    assign count_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        run_d = run_q;
        if (start_i) begin
            cnt_d = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            if (done_o) begin
                cnt_d = '0;
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Front-end controller for TotalALU: one request at a time, sequences DIVU through
// clear / wait / MFHI / MFLO and returns results over a valid/ready response port.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 34,
    parameter int unsigned CNT_W      = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_lo,
    output logic [DATA_W-1:0] rsp_hi,
    output logic              rsp_err,
    output logic [OP_W-1:0]   alu_signal,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_reset,
    input  logic [DATA_W-1:0] alu_out
);

    state_e state_q, state_d;

    logic [OP_W-1:0]   alu_signal_q, alu_signal_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic              alu_reset_q, alu_reset_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_lo_q, rsp_lo_d;
    logic [DATA_W-1:0] rsp_hi_q, rsp_hi_d;
    logic              rsp_err_q, rsp_err_d;

    logic              req_fire;
    logic              rsp_fire;
    logic              timer_start;
    logic              timer_busy;
    logic              timer_done;
    logic [CNT_W-1:0]  timer_count;

    assign req_fire    = req_valid && req_ready;
    assign rsp_fire    = rsp_valid_q && rsp_ready;
    // The counter is armed during the single clear cycle so it reads 0 in the first wait cycle.
    assign timer_start = (state_q == StDivClr);

    alu_div_timer #(
        .DivCycles (DIV_CYCLES),
        .CntW      (CNT_W)
    ) u_div_timer (
        .clk_i   (clk),
        .rst_ni  (reset),
        .start_i (timer_start),
        .busy_o  (timer_busy),
        .done_o  (timer_done),
        .count_o (timer_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req_fire) begin
                    if (is_single_cycle(req_op)) begin
                        state_d = StExec;
                    end else if (is_div(req_op)) begin
                        state_d = StDivClr;
                    end else begin
                        state_d = StResp;
                    end
                end
            end
            StExec:   state_d = StResp;
            StDivClr: state_d = StDivRun;
            StDivRun: begin
                if (timer_done) begin
                    state_d = StRdHi;
                end
            end
            StRdHi:   state_d = StRdLo;
            StRdLo:   state_d = StResp;
            StResp: begin
                if (rsp_fire) begin
                    state_d = StIdle;
                end
            end
            default:  state_d = StIdle;
        endcase
    end

    // Output process: decoded handshake plus next values of the registered ALU/response fields.
    always_comb begin
        req_ready    = (state_q == StIdle);
        alu_signal_d = alu_signal_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_reset_d  = alu_reset_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_lo_d     = rsp_lo_q;
        rsp_hi_d     = rsp_hi_q;
        rsp_err_d    = rsp_err_q;
        unique case (state_q)
            StIdle: begin
                if (req_fire) begin
                    if (is_single_cycle(req_op) || is_div(req_op)) begin
                        alu_signal_d = req_op;
                        alu_a_d      = req_a;
                        alu_b_d      = req_b;
                        alu_reset_d  = is_div(req_op);
                    end else begin
                        // Unsupported code: answer immediately, leave the ALU untouched.
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_lo_d    = '0;
                        rsp_hi_d    = '0;
                    end
                end
            end
            StExec: begin
                rsp_lo_d    = alu_out;
                rsp_hi_d    = '0;
                rsp_err_d   = 1'b0;
                rsp_valid_d = 1'b1;
            end
            StDivClr: begin
                alu_reset_d = 1'b0;
            end
            StDivRun: begin
                if (timer_done) begin
                    alu_signal_d = FN_MFHI;
                end
            end
            StRdHi: begin
                rsp_hi_d     = alu_out;
                alu_signal_d = FN_MFLO;
            end
            StRdLo: begin
                rsp_lo_d    = alu_out;
                rsp_err_d   = 1'b0;
                rsp_valid_d = 1'b1;
            end
            StResp: begin
                if (rsp_fire) begin
                    rsp_valid_d  = 1'b0;
                    alu_signal_d = FN_NOP;
                end
            end
            default: begin
                alu_reset_d = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_signal_q <= FN_NOP;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_reset_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_lo_q     <= '0;
            rsp_hi_q     <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            alu_signal_q <= alu_signal_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_reset_q  <= alu_reset_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_lo_q     <= rsp_lo_d;
            rsp_hi_q     <= rsp_hi_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign alu_signal = alu_signal_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_reset  = alu_reset_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_lo     = rsp_lo_q;
    assign rsp_hi     = rsp_hi_q;
    assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural TotalALU stub and a response scoreboard.
module tb_alu_sequencer;

    localparam int DIV_CYCLES = 34;

    typedef struct packed {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        err;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_lo;
    logic [31:0] rsp_hi;
    logic        rsp_err;
    logic [5:0]  alu_signal;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        alu_reset;
    logic [31:0] alu_out;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    int n_rst;
    int n_div;
    int n_sig;
    int lat16;
    int lat18;

    alu_sequencer #(
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (6)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_lo     (rsp_lo),
        .rsp_hi     (rsp_hi),
        .rsp_err    (rsp_err),
        .alu_signal (alu_signal),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_reset  (alu_reset),
        .alu_out    (alu_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // TotalALU stand-in: HI/LO only become valid after DIV_CYCLES DIVU cycles following a clear.
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    int          m_cnt;

    always @(posedge clk) begin
        if (alu_reset) begin
            m_hi  <= 32'd0;
            m_lo  <= 32'd0;
            m_cnt <= 0;
        end else if (alu_signal == 6'd27) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == DIV_CYCLES - 1) begin
                m_hi <= (alu_b == 32'd0) ? alu_a : alu_a % alu_b;
                m_lo <= (alu_b == 32'd0) ? 32'hFFFF_FFFF : alu_a / alu_b;
            end
        end
    end

    always_comb begin
        alu_out = 32'd0;
        case (alu_signal)
            6'd36:   alu_out = alu_a & alu_b;
            6'd37:   alu_out = alu_a | alu_b;
            6'd32:   alu_out = alu_a + alu_b;
            6'd34:   alu_out = alu_a - alu_b;
            6'd42:   alu_out = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            6'd2:    alu_out = alu_a >> alu_b[4:0];
            6'd16:   alu_out = m_hi;
            6'd18:   alu_out = m_lo;
            default: alu_out = 32'd0;
        endcase
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one request at a negedge; returns at the negedge of cycle T+1.
    task automatic send(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit expect_rsp, input exp_t e);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        if (expect_rsp) sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Called in cycle T+1; samples each cycle until rsp_valid, then scores the response.
    task automatic wait_rsp(input string tag, input int exp_lat);
        int   lat;
        bit   got;
        exp_t e;
        lat   = 1;
        got   = 1'b0;
        n_rst = 0;
        n_div = 0;
        n_sig = 0;
        lat16 = 0;
        lat18 = 0;
        for (int i = 0; i < 200; i++) begin
            if (alu_reset) n_rst++;
            if (alu_signal == 6'd27 && !alu_reset) n_div++;
            if (alu_signal != 6'd0) n_sig++;
            if (alu_signal == 6'd16 && lat16 == 0) lat16 = lat;
            if (alu_signal == 6'd18 && lat18 == 0) lat18 = lat;
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        chk({tag, "_rsp_seen"}, 32'(got), 32'd1);
        if (got) begin
            chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
            chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk({tag, "_lo"}, rsp_lo, e.lo);
                chk({tag, "_hi"}, rsp_hi, e.hi);
                chk({tag, "_err"}, 32'(rsp_err), 32'(e.err));
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_lo"}, rsp_lo, 32'd0);
        chk({tag, "_rsp_hi"}, rsp_hi, 32'd0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        chk({tag, "_alu_signal"}, 32'(alu_signal), 32'd0);
        chk({tag, "_alu_a"}, alu_a, 32'd0);
        chk({tag, "_alu_b"}, alu_b, 32'd0);
        chk({tag, "_alu_reset"}, 32'(alu_reset), 32'd0);
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = 1'b0;
        req_op    = 6'd0;
        req_a     = 32'd0;
        req_b     = 32'd0;
        rsp_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk_reset_outputs("reset");
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);

        // ADD 5 + 7
        send(6'd32, 32'd5, 32'd7, 1'b1, '{lo: 32'd12, hi: 32'd0, err: 1'b0});
        chk("add_signal_t1", 32'(alu_signal), 32'd32);
        chk("add_req_ready_t1", 32'(req_ready), 32'd0);
        wait_rsp("add", 2);
        @(negedge clk);
        chk("add_idle_ready", 32'(req_ready), 32'd1);
        chk("add_idle_signal", 32'(alu_signal), 32'd0);
        chk("add_idle_valid", 32'(rsp_valid), 32'd0);

        // DIVU 100 / 7
        send(6'd27, 32'd100, 32'd7, 1'b1, '{lo: 32'd14, hi: 32'd2, err: 1'b0});
        chk("divu_clr_reset", 32'(alu_reset), 32'd1);
        chk("divu_clr_signal", 32'(alu_signal), 32'd27);
        wait_rsp("divu", DIV_CYCLES + 4);
        chk("divu_reset_pulses", 32'(n_rst), 32'd1);
        chk("divu_run_cycles", 32'(n_div), 32'(DIV_CYCLES));
        chk("divu_mfhi_cycle", 32'(lat16), 32'(DIV_CYCLES + 2));
        chk("divu_mflo_cycle", 32'(lat18), 32'(DIV_CYCLES + 3));
        @(negedge clk);

        // SLT 3 < 9 under backpressure; a queued OR must wait for the handshake
        rsp_ready = 1'b0;
        send(6'd42, 32'd3, 32'd9, 1'b1, '{lo: 32'd1, hi: 32'd0, err: 1'b0});
        wait_rsp("slt", 2);
        req_valid = 1'b1;
        req_op    = 6'd37;
        req_a     = 32'h0000_000C;
        req_b     = 32'h0000_0030;
        sb.push_back('{lo: 32'h0000_003C, hi: 32'd0, err: 1'b0});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_lo", rsp_lo, 32'd1);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_after_hs_valid", 32'(rsp_valid), 32'd0);
        chk("bp_after_hs_ready", 32'(req_ready), 32'd1);
        chk("bp_after_hs_signal", 32'(alu_signal), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("bp_next_accept_signal", 32'(alu_signal), 32'd37);
        wait_rsp("or", 2);
        @(negedge clk);

        // Unsupported op 63
        send(6'd63, 32'd1, 32'd2, 1'b1, '{lo: 32'd0, hi: 32'd0, err: 1'b1});
        wait_rsp("badop", 1);
        chk("badop_no_alu_reset", 32'(n_rst), 32'd0);
        chk("badop_signal_idle", 32'(n_sig), 32'd0);
        @(negedge clk);

        // Reset in DIV_RUN cycle 10, no response for the aborted op
        send(6'd27, 32'd200, 32'd3, 1'b0, '0);
        repeat (11) @(negedge clk);
        chk("abort_in_div_run", 32'(alu_signal), 32'd27);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_outputs("abort_async");
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
            chk("abort_no_clr", 32'(alu_reset), 32'd0);
        end
        send(6'd36, 32'd12, 32'd10, 1'b1, '{lo: 32'd8, hi: 32'd0, err: 1'b0});
        wait_rsp("and", 2);
        @(negedge clk);

        // Back-to-back SRL then SUB with rsp_ready held high
        send(6'd2, 32'h0000_00F0, 32'd4, 1'b1, '{lo: 32'h0000_000F, hi: 32'd0, err: 1'b0});
        wait_rsp("srl", 2);
        req_valid = 1'b1;
        req_op    = 6'd34;
        req_a     = 32'd3;
        req_b     = 32'd5;
        sb.push_back('{lo: 32'hFFFF_FFFE, hi: 32'd0, err: 1'b0});
        @(negedge clk);
        chk("b2b_idle_ready", 32'(req_ready), 32'd1);
        chk("b2b_idle_signal", 32'(alu_signal), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b_sub_signal", 32'(alu_signal), 32'd34);
        wait_rsp("sub", 2);
        @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
